ir_queue_select: RTL and testbench
==================================

Name: ir_queue_select

Overview:
- Next-generation instruction-register unit for the datapath control path.
- Buffers fetched instruction words in a parametrised prefetch queue and loads the head into the IR on command.
- From the IR it produces the opcode, the sign-extended C constant and one-hot register-file in/out enables for NREGS registers.
- Adds selection-error detection and R0-as-zero handling for base-address (BAout) reads.

Parameters:
DATA_W, 32, instruction and bus word width
OPC_W, 5, opcode field width; opcode = IR[DATA_W-1 -: OPC_W]
REG_AW, 4, register field width; NREGS = 2**REG_AW
C_W, 19, C constant field width; C field = IR[C_W-1:0]
DEPTH, 2, prefetch queue entries; power of 2, minimum 2

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
push_valid  in  1  fetched word available on push_data
push_data  in  DATA_W  fetched instruction word
push_ready  out  1  queue can accept a word (count < DEPTH)
ir_load  in  1  load IR from queue head (IRin)
flush  in  1  discard queue contents and invalidate IR
Gra, Grb, Grc  in  1 each  select Ra / Rb / Rc field
Rin, Rout, BAout  in  1 each  register-file write / read / base-address read strobes
ir_valid  out  1  IR holds a valid instruction
load_miss  out  1  one-cycle pulse: ir_load seen with queue empty
opcode  out  OPC_W  IR opcode field
C_sign_extended  out  DATA_W  C field sign-extended from bit C_W-1
reg_in  out  NREGS  one-hot register write enables
reg_out  out  NREGS  one-hot register read enables
sel_err  out  1  more than one of Gra/Grb/Grc asserted
ba_zero  out  1  BAout selected R0; bus must drive zero
q_count  out  $clog2(DEPTH)+1  queue occupancy

Behaviour:
- Field positions:
  - Ra = IR[DATA_W-OPC_W-1 -: REG_AW]
  - Rb = next REG_AW bits below Ra
  - Rc = next REG_AW bits below Rb
  - For defaults: Ra=[26:23], Rb=[22:19], Rc=[18:15].
- Reset: queue empty, both pointers 0, IR=0, ir_valid=0, load_miss=0, push_ready=1.
- Queue is a circular buffer with rd_ptr and wr_ptr modulo DEPTH, plus count.
  - Push accepted iff push_valid && push_ready.
  - push_ready is combinational from the registered count, so a full queue rejects a push even if a pop happens in the same cycle.
- ir_load with count>0: IR <= head, rd_ptr advances, ir_valid <= 1, all in the same edge. New IR is visible the cycle after ir_load.
- ir_load with count==0:
  - No bypass from push_data.
  - IR keeps its value, ir_valid <= 0, load_miss <= 1 for one cycle.
  - A push in the same cycle is still accepted.
- Simultaneous push and load with 0<count<DEPTH: both happen, count unchanged.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble.
- flush has priority over push and ir_load in the same cycle:
  - count <= 0, pointers <= 0, ir_valid <= 0, load_miss <= 0.
  - The IR register value is unchanged.
- reset has priority over everything and aborts any in-flight push or load.
- Combinational decode of the current IR:
  - sel = OR of (field AND its select).
  - sel_err = count of asserted Gra/Grb/Grc is greater than 1.
  - onehot = 1 << sel.
- reg_in = onehot when Rin && ir_valid && !sel_err, else 0.
- Read path, with read_req = (Rout || BAout) && ir_valid && !sel_err:
  - reg_out = onehot when read_req, except 0 when BAout && sel==0.
  - ba_zero = BAout && sel==0 && ir_valid && !sel_err. Rout alone on R0 still enables R0.
- With no select asserted, sel=0, so Rin alone targets R0. This is intentional for compatibility with existing control sequences.
- opcode and C_sign_extended always reflect the IR, independent of ir_valid.
- C_sign_extended = {(DATA_W-C_W) copies of IR[C_W-1], IR[C_W-1:0]}.

Decomposition:
- Shared package (ir_pkg):
  - default widths DATA_W/OPC_W/REG_AW/C_W
  - field-offset constants RA_LSB, RB_LSB, RC_LSB derived from them
- One sub-module, reg_onehot_decoder: parametrised REG_AW-to-NREGS binary-to-one-hot decoder, purely combinational. It replaces the fixed 4-to-16 case decoder.
- Queue and select logic stay in the top module.

Test Plan:
- Reset, then push 0x7291868B; ir_load next cycle -> ir_valid=1, opcode=5'b01110, C_sign_extended=0x0001868B, q_count=0.
- Same IR, driving one select at a time:
  - Gra+Rin -> reg_in=0x0020
  - Grb+Rout -> reg_out=0x0004
  - Grc+Rin -> reg_in=0x0008
  - Gra+Grb+Rin -> sel_err=1, reg_in=0x0000
- Push 0x00040000 and load; then:
  - C_sign_extended=0xFFFC0000
  - Gra+BAout -> reg_out=0, ba_zero=1
  - Gra+Rout -> reg_out=0x0001, ba_zero=0
- Queue behaviour:
  - Push 3 words with DEPTH=2 and no load -> third rejected (push_ready=0 at count=2).
  - Then load+push together until wrap -> words leave in FIFO order, no loss.
- Loads against empty queue and flush:
  - ir_load with empty queue -> load_miss=1 for one cycle, ir_valid=0, IR unchanged.
  - flush asserted with push+ir_load in the same cycle -> q_count=0, ir_valid=0.
- Assert reset mid-stream with count=1 and ir_valid=1 -> next cycle q_count=0, ir_valid=0, IR=0, reg_in=reg_out=0.

Source files
------------

// File: rtl/ir_pkg.sv
// ir_pkg: shared widths and instruction-field offsets for the IR unit.
//   DEF_*      : default widths used as parameter defaults by ir_queue_select
//   field_lsb  : LSB of register field idx (0=Ra, 1=Rb, 2=Rc) for any width set
//   RA/RB/RC_LSB : field offsets for the default widths
package ir_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_OPC_W  = 5;
  localparam int DEF_REG_AW = 4;
  localparam int DEF_C_W    = 19;

  // Register fields sit directly below the opcode, Ra highest, then Rb, Rc.
  function automatic int field_lsb(input int data_w, input int opc_w,
                                   input int reg_aw, input int idx);
    return data_w - opc_w - (idx + 1) * reg_aw;
  endfunction

  localparam int RA_LSB = DEF_DATA_W - DEF_OPC_W - 1 * DEF_REG_AW;
  localparam int RB_LSB = DEF_DATA_W - DEF_OPC_W - 2 * DEF_REG_AW;
  localparam int RC_LSB = DEF_DATA_W - DEF_OPC_W - 3 * DEF_REG_AW;

endpackage

// File: rtl/ir_queue_select_decoder.sv
// reg_onehot_decoder: binary register number to one-hot enable vector.
//   sel_i    [REG_AW-1:0] : register number
//   onehot_o [NREGS-1:0]  : bit sel_i set, all others clear
// Purely combinational.
module reg_onehot_decoder #(
  parameter int REG_AW = 4,
  localparam int NREGS = 2 ** REG_AW
) (
  input  logic [REG_AW-1:0] sel_i,
  output logic [NREGS-1:0]  onehot_o
);

  localparam logic [NREGS-1:0] ONE = {{(NREGS-1){1'b0}}, 1'b1};

  assign onehot_o = ONE << sel_i;

endmodule

// File: rtl/ir_queue_select.sv
// ir_queue_select: instruction register fed from a small prefetch queue,
// with field decode into register-file enables.
//   clk, reset            : clock, synchronous active-high reset
//   push_valid/push_data  : fetched word in; push_ready out (count < DEPTH)
//   ir_load, flush        : load IR from queue head / drop queue and IR valid
//   Gra/Grb/Grc           : select Ra/Rb/Rc register field
//   Rin/Rout/BAout        : register write / read / base-address read strobes
//   ir_valid, load_miss   : IR status, one-cycle pulse on load from empty queue
//   opcode, C_sign_extended : IR fields (always reflect IR contents)
//   reg_in, reg_out       : one-hot register enables
//   sel_err, ba_zero      : multiple selects / BAout on R0 (bus drives zero)
//   q_count               : queue occupancy
//
// Handshake: a word transfers on a rising edge where push_valid && push_ready.
// push_ready depends only on the registered count, so a full queue refuses a
// word even when ir_load frees an entry in the same cycle.
module ir_queue_select
  import ir_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OPC_W  = DEF_OPC_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int C_W    = DEF_C_W,
  parameter int DEPTH  = 2,
  localparam int NREGS = 2 ** REG_AW,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_valid,
  input  logic [DATA_W-1:0] push_data,
  output logic              push_ready,
  input  logic              ir_load,
  input  logic              flush,
  input  logic              Gra,
  input  logic              Grb,
  input  logic              Grc,
  input  logic              Rin,
  input  logic              Rout,
  input  logic              BAout,
  output logic              ir_valid,
  output logic              load_miss,
  output logic [OPC_W-1:0]  opcode,
  output logic [DATA_W-1:0] C_sign_extended,
  output logic [NREGS-1:0]  reg_in,
  output logic [NREGS-1:0]  reg_out,
  output logic              sel_err,
  output logic              ba_zero,
  output logic [CNT_W-1:0]  q_count
);

  localparam int RA_OFF = field_lsb(DATA_W, OPC_W, REG_AW, 0);
  localparam int RB_OFF = field_lsb(DATA_W, OPC_W, REG_AW, 1);
  localparam int RC_OFF = field_lsb(DATA_W, OPC_W, REG_AW, 2);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic              load_miss_q, load_miss_d;

  logic push_fire, pop_fire;

  assign push_ready = (count_q < CNT_W'(DEPTH));
  assign push_fire  = push_valid && push_ready;
  assign pop_fire   = ir_load && (count_q != '0);

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    ir_d        = ir_q;
    ir_valid_d  = ir_valid_q;
    load_miss_d = 1'b0;
    if (flush) begin
      // IR contents are kept; only validity and queue state are dropped.
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      ir_valid_d = 1'b0;
    end else begin
      if (push_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (ir_load) begin
        if (pop_fire) begin
          ir_d       = mem_q[rd_ptr_q];
          rd_ptr_d   = rd_ptr_q + PTR_W'(1);
          ir_valid_d = 1'b1;
        end else begin
          ir_valid_d  = 1'b0;
          load_miss_d = 1'b1;
        end
      end
      count_d = count_q + CNT_W'(push_fire) - CNT_W'(pop_fire);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      ir_q        <= '0;
      ir_valid_q  <= 1'b0;
      load_miss_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      ir_q        <= ir_d;
      ir_valid_q  <= ir_valid_d;
      load_miss_q <= load_miss_d;
    end
  end

  // Storage needs no reset: entries are only read when count says they are live.
  always_ff @(posedge clk) begin
    if (!reset && !flush && push_fire) mem_q[wr_ptr_q] <= push_data;
  end

  assign ir_valid        = ir_valid_q;
  assign load_miss       = load_miss_q;
  assign q_count         = count_q;
  assign opcode          = ir_q[DATA_W-1 -: OPC_W];
  assign C_sign_extended = {{(DATA_W-C_W){ir_q[C_W-1]}}, ir_q[C_W-1:0]};

  // Register select decode.
  logic [REG_AW-1:0] sel;
  logic [NREGS-1:0]  onehot;
  logic              read_req, ba_r0;

  assign sel = (ir_q[RA_OFF +: REG_AW] & {REG_AW{Gra}})
             | (ir_q[RB_OFF +: REG_AW] & {REG_AW{Grb}})
             | (ir_q[RC_OFF +: REG_AW] & {REG_AW{Grc}});

  assign sel_err = (Gra && Grb) || (Gra && Grc) || (Grb && Grc);

  reg_onehot_decoder #(.REG_AW(REG_AW)) u_dec (
    .sel_i    (sel),
    .onehot_o (onehot)
  );

  // BAout on R0 reads constant zero, so the R0 enable is suppressed for it.
  assign ba_r0    = BAout && (sel == '0);
  assign read_req = (Rout || BAout) && ir_valid_q && !sel_err;

  assign reg_in  = (Rin && ir_valid_q && !sel_err) ? onehot : '0;
  assign reg_out = (read_req && !ba_r0) ? onehot : '0;
  assign ba_zero = ba_r0 && ir_valid_q && !sel_err;

endmodule

// File: tb/tb_ir_queue_select.sv
module tb_ir_queue_select;

  localparam int DATA_W = 32;
  localparam int NREGS  = 16;
  localparam int CNT_W  = 2;
  localparam int EW     = 4 + DATA_W;

  // Observed output selectors
  localparam logic [3:0] K_VALID = 4'd0, K_MISS = 4'd1, K_OPC = 4'd2,
                         K_C = 4'd3, K_RIN = 4'd4, K_ROUT = 4'd5,
                         K_SERR = 4'd6, K_BAZ = 4'd7, K_CNT = 4'd8,
                         K_PRDY = 4'd9;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic push_valid = 1'b0;
  logic [DATA_W-1:0] push_data = '0;
  logic push_ready;
  logic ir_load = 1'b0, flush = 1'b0;
  logic Gra = 1'b0, Grb = 1'b0, Grc = 1'b0;
  logic Rin = 1'b0, Rout = 1'b0, BAout = 1'b0;
  logic ir_valid, load_miss, sel_err, ba_zero;
  logic [4:0] opcode;
  logic [DATA_W-1:0] C_sign_extended;
  logic [NREGS-1:0] reg_in, reg_out;
  logic [CNT_W-1:0] q_count;

  ir_queue_select dut (
    .clk(clk), .reset(reset),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
    .ir_load(ir_load), .flush(flush),
    .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .ir_valid(ir_valid), .load_miss(load_miss), .opcode(opcode),
    .C_sign_extended(C_sign_extended), .reg_in(reg_in), .reg_out(reg_out),
    .sel_err(sel_err), .ba_zero(ba_zero), .q_count(q_count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  string tag_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [DATA_W-1:0] observe(input logic [3:0] k);
    case (k)
      K_VALID: return DATA_W'(ir_valid);
      K_MISS:  return DATA_W'(load_miss);
      K_OPC:   return DATA_W'(opcode);
      K_C:     return C_sign_extended;
      K_RIN:   return DATA_W'(reg_in);
      K_ROUT:  return DATA_W'(reg_out);
      K_SERR:  return DATA_W'(sel_err);
      K_BAZ:   return DATA_W'(ba_zero);
      K_CNT:   return DATA_W'(q_count);
      default: return DATA_W'(push_ready);
    endcase
  endfunction

  // Monitor: outputs are sampled on the falling edge, mid-cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [EW-1:0] e;
      string t;
      logic [DATA_W-1:0] act;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      act = observe(e[EW-1 -: 4]);
      checks++;
      if (act !== e[DATA_W-1:0]) begin
        errors++;
        $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", t, act, e[DATA_W-1:0], $time);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    push_valid = 1'b0; push_data = '0; ir_load = 1'b0; flush = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] k, input logic [DATA_W-1:0] v);
    exp_q.push_back({k, v});
    tag_q.push_back(tag);
  endtask

  task automatic push_word(input logic [DATA_W-1:0] w);
    push_valid = 1'b1; push_data = w;
    tick();
    clr();
  endtask

  task automatic load_ir();
    ir_load = 1'b1;
    tick();
    clr();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clr();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    expect_out("rst_cnt", K_CNT, 0);
    expect_out("rst_valid", K_VALID, 0);
    expect_out("rst_miss", K_MISS, 0);
    expect_out("rst_ready", K_PRDY, 1);
    expect_out("rst_opc", K_OPC, 0);
    expect_out("rst_c", K_C, 0);
    tick();

    // First instruction
    push_word(32'h7291868B);
    expect_out("push1_cnt", K_CNT, 1);
    tick();
    load_ir();
    expect_out("ld1_valid", K_VALID, 1);
    expect_out("ld1_opc", K_OPC, 32'h0E);
    expect_out("ld1_c", K_C, 32'h0001868B);
    expect_out("ld1_cnt", K_CNT, 0);
    tick();

    // Field selects: Ra=5, Rb=2, Rc=3
    Gra = 1; Rin = 1;
    expect_out("ra_rin", K_RIN, 32'h0020);
    expect_out("ra_rout0", K_ROUT, 0);
    expect_out("ra_serr", K_SERR, 0);
    tick(); clr();
    Grb = 1; Rout = 1;
    expect_out("rb_rout", K_ROUT, 32'h0004);
    expect_out("rb_rin0", K_RIN, 0);
    tick(); clr();
    Grc = 1; Rin = 1;
    expect_out("rc_rin", K_RIN, 32'h0008);
    tick(); clr();
    Gra = 1; Grb = 1; Rin = 1;
    expect_out("ab_serr", K_SERR, 1);
    expect_out("ab_rin", K_RIN, 0);
    tick(); clr();

    // Negative C, Ra = R0
    push_word(32'h00040000);
    load_ir();
    expect_out("neg_c", K_C, 32'hFFFC0000);
    expect_out("neg_valid", K_VALID, 1);
    tick();
    Gra = 1; BAout = 1;
    expect_out("ba_rout", K_ROUT, 0);
    expect_out("ba_zero", K_BAZ, 1);
    tick(); clr();
    Gra = 1; Rout = 1;
    expect_out("r0_rout", K_ROUT, 32'h0001);
    expect_out("r0_bazero", K_BAZ, 0);
    tick(); clr();

    // Fill queue, third push refused
    push_word(32'h00001111);
    push_valid = 1; push_data = 32'h00002222;
    tick();
    push_valid = 1; push_data = 32'h00003333;
    expect_out("full_cnt", K_CNT, 2);
    expect_out("full_ready", K_PRDY, 0);
    tick(); clr();
    expect_out("rej_cnt", K_CNT, 2);
    tick();

    // Drain with overlapping pushes, through several pointer wraps
    load_ir();
    expect_out("fifo_a", K_C, 32'h00001111);
    expect_out("fifo_a_cnt", K_CNT, 1);
    tick();
    ir_load = 1; push_valid = 1; push_data = 32'h00004444;
    tick(); clr();
    expect_out("fifo_b", K_C, 32'h00002222);
    expect_out("fifo_b_cnt", K_CNT, 1);
    ir_load = 1; push_valid = 1; push_data = 32'h00005555;
    tick(); clr();
    expect_out("fifo_d", K_C, 32'h00004444);
    expect_out("fifo_d_cnt", K_CNT, 1);
    ir_load = 1; push_valid = 1; push_data = 32'h00006666;
    tick(); clr();
    expect_out("fifo_e", K_C, 32'h00005555);
    load_ir();
    expect_out("fifo_f", K_C, 32'h00006666);
    expect_out("fifo_f_cnt", K_CNT, 0);
    tick();

    // Load against empty queue, with a push in the same cycle
    ir_load = 1; push_valid = 1; push_data = 32'h00007777;
    tick(); clr();
    expect_out("miss_pulse", K_MISS, 1);
    expect_out("miss_valid", K_VALID, 0);
    expect_out("miss_ir_kept", K_C, 32'h00006666);
    expect_out("miss_push_cnt", K_CNT, 1);
    tick();
    Gra = 1; Rin = 1;
    expect_out("miss_once", K_MISS, 0);
    expect_out("invalid_rin", K_RIN, 0);
    tick(); clr();

    // Flush beats push and load
    flush = 1; push_valid = 1; push_data = 32'h0000ABCD; ir_load = 1;
    tick(); clr();
    expect_out("flush_cnt", K_CNT, 0);
    expect_out("flush_valid", K_VALID, 0);
    expect_out("flush_miss", K_MISS, 0);
    expect_out("flush_ir_kept", K_C, 32'h00006666);
    tick();
    push_word(32'h7291868B);
    load_ir();
    expect_out("post_flush_c", K_C, 32'h0001868B);
    expect_out("post_flush_opc", K_OPC, 32'h0E);
    tick();

    // Reset mid-stream with count=1 and valid IR
    push_word(32'h00001234);
    expect_out("pre_rst_cnt", K_CNT, 1);
    expect_out("pre_rst_valid", K_VALID, 1);
    tick();
    reset = 1; Gra = 1; Rin = 1; Rout = 1; ir_load = 1;
    tick();
    reset = 0; ir_load = 0;
    expect_out("mrst_cnt", K_CNT, 0);
    expect_out("mrst_valid", K_VALID, 0);
    expect_out("mrst_c", K_C, 0);
    expect_out("mrst_opc", K_OPC, 0);
    expect_out("mrst_rin", K_RIN, 0);
    expect_out("mrst_rout", K_ROUT, 0);
    tick(); clr();

    // Let the monitor drain, bounded
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
